// File: rtl/rails_stack_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rails_stack_checker                                          |
// | Description : Streaming rail-station checker. Cars 1..N arrive in order    |
// |               and may be parked on one LIFO siding; the block receives the |
// |               requested departure order over a valid/ready stream and      |
// |               reports whether the siding can produce it.                   |
// | Option      : define RAILS_FAILIDX_EN to add the fail_idx output.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rails_stack_checker #(
  parameter int DW    = 4,   // width of car IDs, N and index outputs
  parameter int DEPTH = 15   // max cars per frame; DEPTH <= 2^DW-1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] number,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          valid,
  output logic          result
`ifdef RAILS_FAILIDX_EN
  ,
  output logic [DW-1:0] fail_idx
`endif
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DW:0] c_DEPTH = (DW + 1)'(DEPTH);
  localparam logic [DW:0] c_ONE   = (DW + 1)'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RECV = 2'd1;
  localparam logic [1:0] c_PUSH = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // Frame state
  logic [1:0]     r_state;
  logic [DW-1:0]  r_n;        // cars in this frame
  logic [DW-1:0]  r_cnt;      // cars consumed so far
  logic [DW-1:0]  r_cur;      // car waiting for its predecessors to be parked
  logic [DW:0]    r_nxt;      // next car still on the arrival track (one extra bit: N+1 must not wrap)
  logic [SPW-1:0] r_sp;
  logic           r_fail;
  logic [DW-1:0]  r_stack [DEPTH];

  // Handshake decode
  logic           w_accept;
  logic [DW:0]    w_x;
  logic           w_bad_car;
  logic           w_in_order;
  logic           w_ahead;
  logic           w_pop_ok;
  logic [SPW-1:0] w_top_sp;
  logic [DW-1:0]  w_top;
  logic           w_go_push;
  logic           w_set_fail;
  logic           w_adv_nxt;
  logic           w_pop;
  logic           w_push;
  logic           w_consume;
  logic [DW-1:0]  w_cnt_inc;
  logic           w_last;
  logic           w_bad_n;
  logic           w_frame_start;

  assign w_frame_start = (r_state == c_IDLE) && start;
  assign w_bad_n       = (number == '0) || ({1'b0, number} > c_DEPTH);

  assign w_accept   = (r_state == c_RECV) && in_valid;
  assign w_x        = {1'b0, in_data};
  assign w_bad_car  = (in_data == '0) || (in_data > r_n);
  assign w_in_order = (w_x == r_nxt);
  assign w_ahead    = (w_x > r_nxt);

  // Top of the siding; only meaningful when sp is non-zero
  assign w_top_sp = r_sp - SPW'(1);
  assign w_top    = r_stack[w_top_sp[AW-1:0]];
  assign w_pop_ok = (r_sp != '0) && (w_top == in_data);

  // While parking, every cycle moves one car from the arrival track to the siding
  assign w_push = (r_state == c_PUSH) && (r_nxt != {1'b0, r_cur});

  assign w_cnt_inc = r_cnt + DW'(1);
  assign w_last    = (w_cnt_inc == r_n);

  // Classify the accepted car; a car ahead of nxt is held (not consumed) until parking completes
  always_comb begin
    w_go_push  = 1'b0;
    w_set_fail = 1'b0;
    w_adv_nxt  = 1'b0;
    w_pop      = 1'b0;
    w_consume  = 1'b0;
    if (w_accept) begin
      if (r_fail) begin
        w_consume = 1'b1;
      end else if (w_bad_car) begin
        w_set_fail = 1'b1;
        w_consume  = 1'b1;
      end else if (w_in_order) begin
        w_adv_nxt = 1'b1;
        w_consume = 1'b1;
      end else if (w_ahead) begin
        w_go_push = 1'b1;
      end else if (w_pop_ok) begin
        w_pop     = 1'b1;
        w_consume = 1'b1;
      end else begin
        // already departed, or buried under other parked cars
        w_set_fail = 1'b1;
        w_consume  = 1'b1;
      end
    end else if ((r_state == c_PUSH) && !w_push) begin
      w_consume = 1'b1;
    end
  end

  // Control FSM: IDLE -> RECV <-> PUSH -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= w_bad_n ? c_DONE : c_RECV;
          end
        end
        c_RECV: begin
          if (w_go_push) begin
            r_state <= c_PUSH;
          end else if (w_consume && w_last) begin
            r_state <= c_DONE;
          end
        end
        c_PUSH: begin
          if (w_consume) begin
            r_state <= w_last ? c_DONE : c_RECV;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Frame bookkeeping: N, consumed count and the car held during parking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n   <= '0;
      r_cnt <= '0;
      r_cur <= '0;
    end else begin
      if (w_frame_start) begin
        r_n   <= number;
        r_cnt <= '0;
      end else if (w_consume) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_go_push) begin
        r_cur <= in_data;
      end
    end
  end

  // Next car on the arrival track
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nxt <= c_ONE;
    end else if (w_frame_start) begin
      r_nxt <= c_ONE;
    end else if (w_adv_nxt || w_push) begin
      r_nxt <= r_nxt + c_ONE;
    end else if ((r_state == c_PUSH) && w_consume) begin
      // the held car departs directly, so the track resumes just after it
      r_nxt <= {1'b0, r_cur} + c_ONE;
    end
  end

  // Siding pointer; cannot overflow because at most N-1 cars are ever parked
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= '0;
    end else if (w_frame_start) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_pop) begin
      r_sp <= w_top_sp;
    end
  end

  // Siding storage; contents above sp are don't-care so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_sp[AW-1:0]] <= r_nxt[DW-1:0];
    end
  end

  // Sticky failure flag; a bad N fails the frame immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fail <= 1'b0;
    end else if (w_frame_start) begin
      r_fail <= w_bad_n;
    end else if (w_set_fail) begin
      r_fail <= 1'b1;
    end
  end

`ifdef RAILS_FAILIDX_EN
  logic [DW-1:0] r_fail_idx;

  // Capture the 1-based position of the first offending car
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fail_idx <= '0;
    end else if (w_frame_start) begin
      r_fail_idx <= '0;
    end else if (w_set_fail) begin
      r_fail_idx <= w_cnt_inc;
    end
  end

  assign fail_idx = r_fail_idx;
`endif

  assign in_ready = (r_state == c_RECV);
  assign busy     = (r_state != c_IDLE);
  assign valid    = (r_state == c_DONE);
  assign result   = (r_state == c_DONE) && !r_fail;

endmodule
`default_nettype wire

// File: tb/tb_rails_stack_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rails_stack_checker                                       |
// | Description : Self-checking bench for rails_stack_checker with a queue-    |
// |               based reference model and randomized departure orders.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rails_stack_checker;

  localparam int DW    = 5;
  localparam int DEPTH = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] number;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          busy;
  logic          valid;
  logic          result;
`ifdef RAILS_FAILIDX_EN
  logic [DW-1:0] fail_idx;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rails_stack_checker #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .number   (number),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
`ifdef RAILS_FAILIDX_EN
    ,
    .fail_idx (fail_idx)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is either waiting to start, running (with an optional stall while
  // cars are being parked), or reporting its result for one cycle.
  int m_ok = 0, m_active = 0, m_done = 0, m_stall = 0;
  int m_nxt = 1, m_cnt = 0, m_n = 0, m_fail = 0, m_fidx = 0, m_peak = 0;
  int m_stack[$];

  always @(negedge clk) begin
    int x;
    bit cons;
    if (m_ok != 0) begin
      check("busy",     int'(busy),     int'(m_active != 0 || m_done != 0));
      check("in_ready", int'(in_ready), int'(m_active != 0 && m_stall == 0 && m_done == 0));
      check("valid",    int'(valid),    int'(m_done != 0));
      if (m_done != 0) begin
        check("result", int'(result), int'(m_fail == 0));
`ifdef RAILS_FAILIDX_EN
        check("fail_idx", int'(fail_idx), m_fidx);
`endif
      end else begin
        check("result_idle", int'(result), 0);
      end
    end
    cons = 1'b0;
    if (reset) begin
      m_ok = 1; m_active = 0; m_done = 0; m_stall = 0; m_fail = 0; m_fidx = 0;
      m_stack.delete();
    end else if (m_ok != 0) begin
      if (m_done != 0) begin
        m_done = 0;
      end else if (m_active == 0) begin
        if (start) begin
          m_n = int'(number); m_fail = 0; m_fidx = 0; m_peak = 0;
          if (m_n == 0 || m_n > DEPTH) begin
            m_fail = 1; m_done = 1;
          end else begin
            m_active = 1; m_nxt = 1; m_cnt = 0;
            m_stack.delete();
          end
        end
      end else if (m_stall > 0) begin
        m_stall--;
        if (m_stall == 0) cons = 1'b1;
      end else if (in_valid) begin
        x = int'(in_data);
        if (m_fail != 0) begin
          cons = 1'b1;
        end else if (x == 0 || x > m_n) begin
          m_fail = 1; m_fidx = m_cnt + 1; cons = 1'b1;
        end else if (x == m_nxt) begin
          m_nxt++; cons = 1'b1;
        end else if (x > m_nxt) begin
          m_stall = x - m_nxt + 1;
          while (m_nxt < x) begin
            m_stack.push_back(m_nxt);
            m_nxt++;
          end
          m_nxt = x + 1;
          if (m_stack.size() > m_peak) m_peak = m_stack.size();
        end else if (m_stack.size() > 0 && m_stack[$] == x) begin
          void'(m_stack.pop_back());
          cons = 1'b1;
        end else begin
          m_fail = 1; m_fidx = m_cnt + 1; cons = 1'b1;
        end
      end
      if (cons) begin
        m_cnt++;
        if (m_cnt == m_n) begin
          m_active = 0; m_done = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame. Returns result, fail index, number of cycles the car was
  // offered but not taken, and how many extra cycles valid took after the last
  // handshake. abort_after >= 0 stops after that many handshakes.
  task automatic run_frame(input int n, input int cars[$], input int gap_pct,
                           input int abort_after, input bit mid_start,
                           output int res, output int fidx, output int stalls, output int lat);
    int idx;
    int guard;
    bit hs;
    res = -1; fidx = -1; stalls = 0; lat = -1; idx = 0;
    guard = 0;
    while (busy && guard < 200) begin
      tick();
      guard++;
    end
    if (busy) check("idle_timeout", int'(busy), 0);
    start = 1'b1;
    number = DW'(n);
    tick();
    start = 1'b0;
    number = DW'($urandom);
    guard = 0;
    while (idx < cars.size() && idx != abort_after && guard < 2000) begin
      guard++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(cars[idx]);
      end
      if (mid_start && idx == 1) begin
        start = 1'b1;
        number = DW'(7);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      tick();
      if (hs) idx++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (guard >= 2000) check("car_timeout", idx, cars.size());
    if (abort_after >= 0 && idx == abort_after) return;
    guard = 0;
    @(negedge clk);
    while (!valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("valid_seen", int'(valid), 1);
    lat = guard;
    res = int'(result);
`ifdef RAILS_FAILIDX_EN
    fidx = int'(fail_idx);
`else
    fidx = 0;
`endif
    tick();
  endtask

  task automatic pin_idx(input string name, input int act, input int exp);
`ifdef RAILS_FAILIDX_EN
    check(name, act, exp);
`endif
  endtask

  initial begin
    int cars[$];
    int res, fidx, stalls, lat;
    int n, mode, nx, tmp, j;
    int stk[$];

    reset = 1'b1; start = 1'b0; number = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    check("rst_busy",     int'(busy),     0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_valid",    int'(valid),    0);
    check("rst_result",   int'(result),   0);
    reset = 1'b0;
    tick();

    // in order: no stalls, result one cycle after the 5th handshake
    cars = '{1, 2, 3, 4, 5};
    run_frame(5, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("inorder_result", res, 1);
    check("inorder_stalls", stalls, 0);
    check("inorder_latency", lat, 0);
    pin_idx("inorder_idx", fidx, 0);

    // full reversal: 4 pushes + 1 cycle of stall, siding peaks at 4
    cars = '{5, 4, 3, 2, 1};
    run_frame(5, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("reverse_result", res, 1);
    check("reverse_stalls", stalls, 5);
    check("reverse_peak", m_peak, 4);

    // buried car
    cars = '{5, 4, 1, 2, 3};
    run_frame(5, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("buried_result", res, 0);
    pin_idx("buried_idx", fidx, 3);

    // duplicate
    cars = '{2, 2, 1, 3};
    run_frame(4, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("dup_result", res, 0);
    pin_idx("dup_idx", fidx, 2);

    // out of range
    cars = '{2, 9, 1, 3};
    run_frame(4, cars, 20, -1, 1'b0, res, fidx, stalls, lat);
    check("range_result", res, 0);
    pin_idx("range_idx", fidx, 2);

    // bad and boundary N
    cars = {};
    run_frame(0, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("n0_result", res, 0);
    check("n0_latency", lat, 0);
    pin_idx("n0_idx", fidx, 0);
    run_frame(16, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("n16_result", res, 0);
    check("n16_latency", lat, 0);
    cars = {};
    for (int i = 1; i <= 15; i++) cars.push_back(i);
    run_frame(15, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("n15_result", res, 1);

    // start during a running frame must be ignored
    cars = '{3, 2, 1};
    run_frame(3, cars, 0, -1, 1'b1, res, fidx, stalls, lat);
    check("midstart_result", res, 1);

    // reset mid-frame, with a car left parked
    cars = '{3, 2, 1, 4, 5};
    run_frame(5, cars, 0, 2, 1'b0, res, fidx, stalls, lat);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    repeat (3) begin
      tick();
      check("abort_no_valid", int'(valid), 0);
    end
    cars = '{3, 2, 1};
    run_frame(3, cars, 0, -1, 1'b0, res, fidx, stalls, lat);
    check("after_abort_result", res, 1);

    // randomized frames
    for (int f = 0; f < 80; f++) begin
      cars = {};
      n = $urandom_range(1, DEPTH);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        stk = {};
        nx = 1;
        while (cars.size() < n) begin
          if (nx <= n && (stk.size() == 0 || $urandom_range(1) == 1)) begin
            stk.push_back(nx);
            nx++;
          end else begin
            cars.push_back(stk.pop_back());
          end
        end
      end else if (mode == 1) begin
        for (int i = 1; i <= n; i++) cars.push_back(i);
        for (int i = n - 1; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = cars[i]; cars[i] = cars[j]; cars[j] = tmp;
        end
      end else if (mode == 2) begin
        for (int i = 0; i < n; i++) cars.push_back($urandom_range(0, n + 2));
      end else begin
        n = ($urandom_range(1) == 1) ? 0 : $urandom_range(DEPTH + 1, 31);
      end
      run_frame(n, cars, $urandom_range(0, 40), -1, 1'b0, res, fidx, stalls, lat);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rails_stack_checker.md
Name: rails_stack_checker

Overview:
Parametrised streaming checker for the rail-station problem. Cars 1..N arrive in ascending order and may only be parked on a single LIFO siding. The block receives the requested departure order one car per handshake and reports whether a stack can produce that order. It is the generalised successor of the fixed-width checker: DEPTH and DW are parameters, it uses a valid/ready input stream and an explicit frame start, it detects out-of-range or duplicate cars, and it has deterministic push latency.

Parameters:
DW, 4, width of number, car IDs and index outputs
DEPTH, 15, maximum cars per frame and stack depth; must satisfy DEPTH <= 2^DW-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears FSM, stack pointer, counters and outputs
start  in  1  frame start pulse; sampled only in IDLE
number  in  DW  car count N for the frame, latched on accepted start
in_valid  in  1  departure car present
in_data  in  DW  departure car ID
in_ready  out  1  block accepts in_data this cycle
busy  out  1  high whenever FSM is not IDLE
valid  out  1  one-cycle result strobe
result  out  1  1 = order achievable; qualified by valid

Behaviour:
- Reset values: valid=0, result=0, busy=0, in_ready=0, sp=0, FSM=IDLE. Reset mid-frame aborts the frame with no valid pulse and clears all stack state.
- Internal state: stack[DEPTH] of DW bits; sp of width clog2(DEPTH+1); nxt = next unparked car, starting at 1; cnt = cars consumed; fail flag; cur = car under processing.
- IDLE: on start, latch N=number and set nxt=1, cnt=0, sp=0, fail=0.
  - If N==0 or N>DEPTH, go to DONE with result=0.
  - Otherwise go to RECV.
  - start is ignored in every other state.
- RECV: in_ready=1. On in_valid&&in_ready, let x=in_data:
  - fail already set: consume only.
  - x==0 or x>N: set fail; consume.
  - x==nxt: nxt<=nxt+1; consume.
  - x>nxt: cur<=x; go to PUSH; the car is not yet consumed.
  - x<nxt and sp>0 and stack[sp-1]==x: pop (sp<=sp-1); consume.
  - x<nxt otherwise (already departed, or buried under other cars): set fail; consume.
- PUSH: in_ready=0.
  - While nxt!=cur: push nxt (stack[sp]<=nxt, sp<=sp+1), then nxt<=nxt+1.
  - In the cycle where nxt==cur: nxt<=cur+1; consume; return to RECV.
  - PUSH occupancy for car x is exactly (x - nxt_at_entry) + 1 cycles.
- Consume means cnt<=cnt+1. When cnt reaches N, go to DONE instead of RECV.
- After fail is set, the remaining cars are still absorbed at one per handshake so the upstream frame stays aligned.
- DONE: valid=1 for exactly one cycle, result=!fail, busy=1; then go to IDLE. Latency: valid is high in the cycle after the edge that consumes the N-th car.
- Stack cannot overflow, because sp <= N-1 <= DEPTH-1. Arithmetic on nxt uses DW+1 bits so nxt=N+1 does not wrap.
- in_data is ignored when in_valid=0. Gaps in in_valid stall RECV indefinitely with no timeout.

Optional Feature:
RAILS_FAILIDX_EN
- Defined: adds output fail_idx [DW-1:0], registered.
  - Holds the 1-based index of the first offending car, or 0 if result=1.
  - Qualified by valid; reset value 0.
  - A bad N gives fail_idx=0 with result=0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- N=5, cars 1,2,3,4,5, in_valid held high -> in_ready never drops; valid one cycle after the 5th accept; result=1.
- N=5, cars 5,4,3,2,1 -> in_ready low for 5 cycles after the first accept (4 pushes + 1), sp peaks at 4; result=1.
- N=5, cars 5,4,1,2,3 -> fail on car 3 (top is 3, not 1); cars 2,3 still absorbed; result=0; fail_idx=3 if RAILS_FAILIDX_EN.
- N=4, cars 2,2,1,3 -> duplicate caught on car 2; result=0. Same frame with car 9 -> out-of-range fail; result=0.
- start with number=0, and with number=15 vs 16 at DEPTH=15 -> 0 and 16 give valid in the cycle after start with result=0; 15 is accepted.
- Assert reset after 2 cars of an N=5 frame -> busy=0, valid never pulses. Then N=3 with cars 3,2,1 -> result=1 (no stale stack). A start pulse during RUN is ignored.
